// File: rtl/cfg_latch_pkg.sv
// Shared constants for the configuration latch sequencer: state encoding,
// register map, CTRL/STATUS bit positions and index sizing.
package cfg_latch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_PULSE = 2'd2;
  localparam state_t ST_GAP   = 2'd3;

  localparam logic [5:0] ADDR_CTRL   = 6'h38;
  localparam logic [5:0] ADDR_STATUS = 6'h3C;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_SINGLE  = 1;
  localparam int unsigned CTRL_IDX_LO  = 8;
  localparam int unsigned CTRL_IDX_HI  = 12;
  localparam int unsigned CTRL_CLR_ERR = 31;

  localparam int unsigned STAT_BUSY = 10;
  localparam int unsigned STAT_ERR  = 31;

  // Index register width; a single bank still needs one bit.
  function automatic int unsigned idx_bits(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/cfg_latch_timer.sv
// Shared phase timer: loaded with (cycles-1) on phase entry, expire_c flags
// the last cycle of the phase.
module cfg_latch_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/cfg_latch_sequencer.sv
// Bus-loaded multi-word staging register plus a timed sequencer that pulses
// one-hot latch enables into DEPTH configuration latch banks.
module cfg_latch_sequencer
  import cfg_latch_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned PULSE_CYC  = 1,
  parameter int unsigned GAP_CYC    = 1,
  parameter int unsigned AUTO_START = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_req,
  input  logic [5:0]       address,
  input  logic [31:0]      data_in,
  output logic [31:0]      read_data,
  output logic [WIDTH-1:0] config_data,
  output logic [DEPTH-1:0] latch_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NWORDS  = (WIDTH + 31) / 32;
  localparam int unsigned PAD_W   = NWORDS * 32;
  localparam int unsigned IDX_W   = idx_bits(DEPTH);
  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC <= 1) ? 1 : $clog2(MAX_CYC);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             single_q, single_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DEPTH-1:0] latch_q, latch_d;
  logic [WIDTH-1:0] cfg_q, cfg_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_expire_c;

  logic [3:0]       word_sel;
  logic             data_hit, ctrl_hit, start_req, req_single, bad_idx, start_ok, new_err;
  logic [4:0]       req_idx;
  logic [PAD_W-1:0] cfg_pad;

  // Bus decode and start/error qualification
  always_comb begin
    word_sel   = address[5:2];
    data_hit   = write_req && (address[1:0] == 2'b00) && (32'(word_sel) < NWORDS);
    ctrl_hit   = write_req && (address == ADDR_CTRL);
    req_idx    = data_in[CTRL_IDX_HI:CTRL_IDX_LO];
    req_single = ctrl_hit && data_in[CTRL_START] && data_in[CTRL_SINGLE];
    start_req  = (ctrl_hit && data_in[CTRL_START]) ||
                 ((AUTO_START != 0) && data_hit && (32'(word_sel) == NWORDS - 1));
    bad_idx    = req_single && (32'(req_idx) >= DEPTH);
    start_ok   = start_req && !busy_q && !bad_idx;
    new_err    = (data_hit && busy_q) || (start_req && busy_q) || bad_idx;
  end

  // Staging register: only bits inside WIDTH exist, the rest read as zero
  always_comb begin
    cfg_d = cfg_q;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (data_hit && !busy_q && (word_sel == 4'(b / 32))) begin
        cfg_d[b] = data_in[b % 32];
      end
    end
  end

  assign cfg_pad = PAD_W'(cfg_q);

  always_comb begin
    read_data = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (address == 6'(4 * i)) begin
        read_data = cfg_pad[32*i +: 32];
      end
    end
    if (address == ADDR_STATUS) begin
      read_data[STAT_ERR]  = err_q;
      read_data[STAT_BUSY] = busy_q;
      read_data[4:0]       = 5'(idx_q);
    end
  end

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    single_d   = single_q;
    err_d      = err_q;
    done_d     = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_SETUP;
          single_d = req_single;
          idx_d    = req_single ? IDX_W'(req_idx) : IDX_W'(DEPTH - 1);
        end
      end
      ST_SETUP: if (timer_expire_c) state_d = ST_PULSE;
      ST_PULSE: if (timer_expire_c) state_d = ST_GAP;
      ST_GAP: begin
        if (timer_expire_c) begin
          if (single_q || (idx_q == '0)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ST_SETUP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ctrl_hit && data_in[CTRL_CLR_ERR]) err_d = 1'b0;
    if (new_err) err_d = 1'b1;

    if ((state_d != state_q) && (state_d != ST_IDLE)) begin
      timer_load = 1'b1;
      case (state_d)
        ST_SETUP: timer_val = CNT_W'(SETUP_CYC - 1);
        ST_PULSE: timer_val = CNT_W'(PULSE_CYC - 1);
        default:  timer_val = CNT_W'(GAP_CYC - 1);
      endcase
    end

    busy_d  = (state_d != ST_IDLE);
    latch_d = (state_d == ST_PULSE) ? (DEPTH'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      single_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      latch_q  <= '0;
      cfg_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      single_q <= single_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      latch_q  <= latch_d;
      cfg_q    <= cfg_d;
    end
  end

  cfg_latch_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expire_c (timer_expire_c)
  );

  assign config_data = cfg_q;
  assign latch_en    = latch_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
